add8_sched: RTL and testbench
=============================

# add8_sched

Two-requester scheduler that shares a single external 8-bit ripple adder (9-bit `{carry, sum}` result) to perform multi-byte additions. It arbitrates round-robin between two requesters and sequences one operand byte per cycle through the adder, LSB first, chaining the carry in a register. It returns a `8*BYTES+1`-bit sum with the winning requester's ID over a valid/ready result channel.

## Interface
Parameters:
- `BYTES`, default 4: operand width in bytes; must be ≥ 1. Operand width `W = 8*BYTES`.

Ports (clock and reset first). One clock; reset is asynchronous and active-low.
- `clk`, in, 1: sole clock, rising edge.
- `rst_n`, in, 1: asynchronous active-low reset.
- `req0_valid`, in, 1: requester 0 has an operation.
- `req0_ready`, out, 1: requester 0 operands accepted this cycle.
- `req0_a`, `req0_b`, in, W: requester 0 operands.
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`: same as requester 0, for requester 1.
- `add_a`, out, 8: byte to adder input A.
- `add_b`, out, 8: byte to adder input B.
- `add_cin`, out, 1: adder carry-in.
- `add_v`, in, 9: adder result `{cout, sum[7:0]}`. The adder is combinational and returns its result in the same cycle.
- `res_valid`, out, 1: result available.
- `res_ready`, in, 1: consumer accepts result.
- `res_sum`, out, W+1: completed sum; bit W is the final carry.
- `res_id`, out, 1: requester that owns `res_sum`.

## Operation
- States:
  - IDLE: accept a request.
  - RUN: byte sequencing.
  - DONE: holding the result.
- Arbitration (in IDLE only):
  - If exactly one `reqN_valid` is high, grant N.
  - If both are high, grant the requester that was not granted last.
  - `last_grant` resets to 1, so requester 0 wins the first tie.
  - `reqN_ready = (state==IDLE) && grant==N && reqN_valid`. This is combinational, and at most one ready is high.
- Accept (`reqN_valid && reqN_ready` at an edge):
  - Capture a, b.
  - Set `res_id` = N and `last_grant` = N.
  - Set byte index `idx` = 0 and carry register = 0.
  - Go to RUN.
- RUN, each cycle:
  - `add_a = a[8*idx +: 8]`, `add_b = b[8*idx +: 8]`, `add_cin = carry`.
  - At the edge: store `add_v[7:0]` into `sum[8*idx +: 8]`, set `carry <= add_v[8]`, set `idx <= idx+1`.
  - When `idx == BYTES-1`, also set `sum[W] <= add_v[8]` and go to DONE.
- DONE:
  - `res_valid` = 1.
  - `res_sum` and `res_id` are held stable.
  - On `res_valid && res_ready`, return to IDLE.
- Outside RUN, `add_a`, `add_b` and `add_cin` are driven to 0.
- Arithmetic: unsigned; `res_sum = a + b` exactly, no truncation; W+1 bits always suffice.
- Requesters must hold valid and operands stable until ready. Operands are sampled only at the accept edge; later changes have no effect.
- Reset values:
  - state IDLE, `idx` 0, carry 0, `last_grant` 1.
  - `res_valid` 0, `res_sum` 0, `res_id` 0.
  - `add_a`, `add_b`, `add_cin` all 0; both readies 0 unless granted in IDLE.
- Reset mid-operation: the operation is abandoned, and no result is ever produced for it.

## Timing
- Accept edge E0. RUN covers the BYTES cycles after E0.
- `res_valid` rises after edge E0+BYTES.
- Latency from accept to `res_valid` is BYTES cycles.
- Minimum spacing between accepts is BYTES+2 cycles: 1 IDLE, BYTES RUN, 1 DONE with `res_ready` = 1.
- Result backpressure: `res_ready` low keeps the block in DONE indefinitely, with both readies 0.
- A request arriving while busy waits. The arbiter re-evaluates in the first IDLE cycle, so a waiting request is accepted there.
- `BYTES=1`: RUN lasts one cycle.
- Reset assertion takes effect immediately (asynchronous). The first accept is possible at the first rising edge after `rst_n` deasserts.

## Test plan
- Carry within byte, BYTES=4: req0 a=0x000000FF, b=0x00000001 → `res_sum`=0x000000100, `res_id`=0, `res_valid` 4 cycles after accept; `add_cin` sequence 0,1,0,0.
- Full carry ripple: req1 a=0xFFFFFFFF, b=0x00000001 → `res_sum`=0x100000000, `res_id`=1; carry 1 at every byte.
- Tie after reset: req0 (1,2) and req1 (3,4) both valid → results id0 sum 3, then id1 sum 7. Holding both requesters valid keeps outcomes alternating 0,1,0,1.
- Backpressure: `res_ready`=0 for 5 cycles in DONE → `res_valid`, `res_sum` and `res_id` stable, both readies 0, adder inputs 0; accepted on the cycle `res_ready`=1, and IDLE follows.
- Reset mid-RUN (after 2 bytes): all outputs go to reset values immediately; after release no `res_valid` appears; a new req0 (5,6) then yields 11 normally.
- BYTES=1: a=0x80, b=0x80 → `res_sum`=0x100 one cycle after accept; a=0x00, b=0x00 → 0x000.

Source files
------------

// File: rtl/add8_sched.sv
// rtl/add8_sched.sv - two-requester round-robin scheduler sharing one external 8-bit adder
// Multi-byte sums are built LSB first, one byte per cycle, with the carry chained in a register.
module add8_sched #(
  parameter int BYTES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [8*BYTES-1:0] req0_a,
  input  logic [8*BYTES-1:0] req0_b,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [8*BYTES-1:0] req1_a,
  input  logic [8*BYTES-1:0] req1_b,
  output logic [7:0]         add_a,
  output logic [7:0]         add_b,
  output logic               add_cin,
  input  logic [8:0]         add_v,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [8*BYTES:0]   res_sum,
  output logic               res_id
);

  localparam int W  = 8 * BYTES;
  localparam int IW = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(BYTES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    r_state;
  logic [IW-1:0] r_idx;
  logic          r_carry;
  logic          r_last_grant;
  logic          r_id;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [W:0]    r_sum;

  logic w_idle;
  logic w_run;
  logic w_grant;

  assign w_idle = (r_state == S_IDLE);
  assign w_run  = (r_state == S_RUN);

  // On a tie the requester not served last wins; otherwise whoever is asking.
  assign w_grant = (req0_valid && req1_valid) ? ~r_last_grant : req1_valid;

  assign req0_ready = w_idle && !w_grant && req0_valid;
  assign req1_ready = w_idle &&  w_grant && req1_valid;

  assign add_a   = w_run ? r_a[8*r_idx +: 8] : 8'd0;
  assign add_b   = w_run ? r_b[8*r_idx +: 8] : 8'd0;
  assign add_cin = w_run ? r_carry : 1'b0;

  assign res_valid = (r_state == S_DONE);
  assign res_sum   = r_sum;
  assign res_id    = r_id;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_carry      <= 1'b0;
      r_last_grant <= 1'b1;
      r_id         <= 1'b0;
      r_a          <= '0;
      r_b          <= '0;
      r_sum        <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req0_ready || req1_ready) begin
            r_a          <= req1_ready ? req1_a : req0_a;
            r_b          <= req1_ready ? req1_b : req0_b;
            r_id         <= req1_ready;
            r_last_grant <= req1_ready;
            r_idx        <= '0;
            r_carry      <= 1'b0;
            r_state      <= S_RUN;
          end
        end
        S_RUN: begin
          r_sum[8*r_idx +: 8] <= add_v[7:0];
          r_carry             <= add_v[8];
          r_idx               <= r_idx + 1'b1;
          if (r_idx == LAST_IDX) begin
            r_sum[W] <= add_v[8];
            r_state  <= S_DONE;
          end
        end
        S_DONE: begin
          if (res_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_add8_sched.sv
// tb/tb_add8_sched.sv - scoreboard bench for add8_sched (BYTES=4 and BYTES=1 instances)
module tb_add8_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [7:0]  add_a, add_b;
  logic        add_cin;
  logic [8:0]  add_v;
  logic        res_valid, res_ready, res_id;
  logic [32:0] res_sum;

  logic        s_req0_valid, s_req0_ready, s_req1_valid, s_req1_ready;
  logic [7:0]  s_req0_a, s_req0_b, s_req1_a, s_req1_b;
  logic [7:0]  s_add_a, s_add_b;
  logic        s_add_cin;
  logic [8:0]  s_add_v;
  logic        s_res_valid, s_res_ready, s_res_id;
  logic [8:0]  s_res_sum;

  assign add_v   = {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_cin};
  assign s_add_v = {1'b0, s_add_a} + {1'b0, s_add_b} + {8'd0, s_add_cin};

  add8_sched #(.BYTES(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_v(add_v),
    .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum), .res_id(res_id)
  );

  add8_sched #(.BYTES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(s_req0_valid), .req0_ready(s_req0_ready), .req0_a(s_req0_a), .req0_b(s_req0_b),
    .req1_valid(s_req1_valid), .req1_ready(s_req1_ready), .req1_a(s_req1_a), .req1_b(s_req1_b),
    .add_a(s_add_a), .add_b(s_add_b), .add_cin(s_add_cin), .add_v(s_add_v),
    .res_valid(s_res_valid), .res_ready(s_res_ready), .res_sum(s_res_sum), .res_id(s_res_id)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [33:0] q4[$];
  logic [9:0]  q1[$];
  logic [33:0] e4;
  logic [9:0]  e1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && res_valid && res_ready) begin
      if (q4.size() == 0) chk("d4_unexpected_result", 1, 0);
      else begin
        e4 = q4.pop_front();
        chk("d4_res_sum", res_sum, e4[32:0]);
        chk("d4_res_id", res_id, e4[33]);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && s_res_valid && s_res_ready) begin
      if (q1.size() == 0) chk("d1_unexpected_result", 1, 0);
      else begin
        e1 = q1.pop_front();
        chk("d1_res_sum", s_res_sum, e1[8:0]);
        chk("d1_res_id", s_res_id, e1[9]);
      end
    end
  end

  task automatic send4(input int who, input logic [31:0] a, input logic [31:0] b,
                       input logic [32:0] exp_sum, input bit push);
    bit got;
    logic id;
    id = (who != 0);
    if (push) q4.push_back({id, exp_sum});
    @(posedge clk); #1;
    if (!id) begin req0_a = a; req0_b = b; req0_valid = 1'b1; end
    else     begin req1_a = a; req1_b = b; req1_valid = 1'b1; end
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (id ? req1_ready : req0_ready) got = 1'b1;
    end
    chk("d4_accept_timeout", got, 1);
    @(posedge clk); #1;
    if (!id) req0_valid = 1'b0; else req1_valid = 1'b0;
  endtask

  task automatic send1(input logic [7:0] a, input logic [7:0] b, input logic [8:0] exp_sum);
    bit got;
    q1.push_back({1'b0, exp_sum});
    @(posedge clk); #1;
    s_req0_a = a; s_req0_b = b; s_req0_valid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (s_req0_ready) got = 1'b1;
    end
    chk("d1_accept_timeout", got, 1);
    @(posedge clk); #1;
    s_req0_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && (q4.size() != 0 || q1.size() != 0); i++) @(negedge clk);
    chk("drain_q4_empty", q4.size(), 0);
    chk("drain_q1_empty", q1.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic run_seq4(input string tag, input logic [3:0] exp_cin);
    logic [3:0] seq;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      seq[k] = add_cin;
      chk({tag, "_valid_early"}, res_valid, 0);
    end
    chk({tag, "_cin_seq"}, seq, exp_cin);
    @(negedge clk);
    chk({tag, "_latency"}, res_valid, 1);
  endtask

  initial begin
    int cnt;
    logic [3:0] ord;
    bit seen;

    rst_n = 1'b0;
    req0_valid = 0; req1_valid = 0; req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
    res_ready = 1'b1;
    s_req0_valid = 0; s_req1_valid = 0; s_req0_a = 0; s_req0_b = 0; s_req1_a = 0; s_req1_b = 0;
    s_res_ready = 1'b1;

    repeat (2) @(negedge clk);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_sum", res_sum, 0);
    chk("rst_res_id", res_id, 0);
    chk("rst_adder_in", {add_a, add_b, add_cin}, 0);
    chk("rst_readies", {req0_ready, req1_ready}, 0);
    @(posedge clk); #1; rst_n = 1'b1;

    // Carry within a byte
    send4(0, 32'h000000FF, 32'h00000001, 33'h000000100, 1);
    run_seq4("t1", 4'b0010);
    drain();

    // Carry ripples through every byte
    send4(1, 32'hFFFFFFFF, 32'h00000001, 33'h100000000, 1);
    run_seq4("t2", 4'b1110);
    drain();

    // Tie right after reset: grants alternate starting with requester 0
    @(posedge clk); #1; rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1;
    q4.push_back({1'b0, 33'd3}); q4.push_back({1'b1, 33'd7});
    q4.push_back({1'b0, 33'd3}); q4.push_back({1'b1, 33'd7});
    @(posedge clk); #1;
    req0_a = 1; req0_b = 2; req1_a = 3; req1_b = 4;
    req0_valid = 1'b1; req1_valid = 1'b1;
    cnt = 0; ord = '0;
    for (int i = 0; i < 100 && cnt < 4; i++) begin
      @(negedge clk);
      if (req0_ready || req1_ready) begin
        chk("t3_one_ready", req0_ready & req1_ready, 0);
        ord[cnt] = req1_ready;
        cnt++;
      end
    end
    chk("t3_grant_order", ord, 4'b1010);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    drain();

    // Backpressure in DONE with requester 1 waiting
    res_ready = 1'b0;
    send4(0, 32'h12345678, 32'h11111111, 33'h023456789, 1);
    q4.push_back({1'b1, 33'd3});
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = res_valid;
    end
    chk("t4_valid_seen", seen, 1);
    @(posedge clk); #1;
    req1_a = 1; req1_b = 2; req1_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t4_hold_valid", res_valid, 1);
      chk("t4_hold_sum", res_sum, 33'h023456789);
      chk("t4_hold_id", res_id, 0);
      chk("t4_hold_readies", {req0_ready, req1_ready}, 0);
      chk("t4_hold_adder", {add_a, add_b, add_cin}, 0);
    end
    @(posedge clk); #1; res_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t4_idle_valid", res_valid, 0);
    chk("t4_waiting_ready", req1_ready, 1);
    @(posedge clk); #1; req1_valid = 1'b0;
    drain();

    // Reset in the middle of RUN abandons the operation
    send4(0, 32'h00AAAAAA, 32'h00555555, 33'd0, 0);
    @(posedge clk); @(posedge clk); #1;
    chk("t5_running_add_a", add_a, 8'hAA);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_add_a", add_a, 0);
    chk("t5_rst_add_cin", add_cin, 0);
    chk("t5_rst_res_sum", res_sum, 0);
    chk("t5_rst_res_valid", res_valid, 0);
    chk("t5_rst_res_id", res_id, 0);
    @(posedge clk); @(posedge clk); #1; rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("t5_no_result", res_valid, 0);
    end
    send4(0, 32'd5, 32'd6, 33'd11, 1);
    drain();

    // BYTES=1 instance
    send1(8'h80, 8'h80, 9'h100);
    @(negedge clk);
    chk("t6_valid_early", s_res_valid, 0);
    @(negedge clk);
    chk("t6_latency", s_res_valid, 1);
    drain();
    send1(8'h00, 8'h00, 9'h000);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
